// File: rtl/rv_mem_pkg.sv
// Shared types for the FROG RV32I memory-access stage.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } t_mem_size;

    typedef enum logic [1:0] {
        SEL_WB_ALU = 2'd0,
        SEL_WB_MEM = 2'd1,
        SEL_WB_PC4 = 2'd2
    } t_sel_wb;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RSP = 1'b1
    } t_mem_state;

    typedef struct packed {
        logic       mem_rd_en;
        logic       mem_wr_en;
        t_mem_size  mem_size;
        logic       mem_unsigned;
        t_sel_wb    sel_wb;
        logic [4:0] rd_Q103H;
        logic       reg_write_en_Q103H;
    } t_mem_ctrl;

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic addr_misaligned(input t_mem_size size, input logic [1:0] lo);
        case (size)
            MEM_H:   return lo[0];
            MEM_W:   return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv_mem_align.sv
// Byte-lane steering: store byte enables and replication, load extraction and extension.
import rv_mem_pkg::*;

module rv_mem_align (
    input  t_mem_size   size,
    input  logic        unsigned_ld,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: lanes enabled by size and address, data replicated across lanes.
    always_comb begin
        be    = 4'b1111;
        wdata = wd;
        case (size)
            MEM_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{wd[7:0]}};
            end
            MEM_H: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wd[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wd;
            end
        endcase
    end

    // Load side: pick the addressed lane, then zero or sign extend.
    always_comb begin
        case (addr_lo)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_B:   ld_data = unsigned_ld ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            MEM_H:   ld_data = unsigned_ld ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/rv_mem.sv
// FROG RV32I memory-access stage: data-memory handshake, stall control, Q104H write-back register.
import rv_mem_pkg::*;

module rv_mem (
    input  logic        clk,
    input  logic        rst,
    input  t_mem_ctrl   ctrl,
    input  logic        flush_Q103H,
    input  logic [31:0] alu_out_Q103H,
    input  logic [31:0] pc_plus4_Q103H,
    input  logic [31:0] dmem_wr_data_Q103H,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [3:0]  dmem_req_be,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        stall_Q103H,
    output logic [31:0] wb_data_Q103H,
    output logic [31:0] wb_data_Q104H,
    output logic [4:0]  rd_Q104H,
    output logic        reg_write_en_Q104H,
    output logic        misalign_Q104H
);

    t_mem_state  state_q, state_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_we_q, reg_we_d;
    logic        misalign_q, misalign_d;

    logic        any_mem;
    logic        misalign;
    logic        flush_eff;
    logic        mem_req;
    logic [31:0] ld_data;

    rv_mem_align u_align (
        .size        (ctrl.mem_size),
        .unsigned_ld (ctrl.mem_unsigned),
        .addr_lo     (alu_out_Q103H[1:0]),
        .wd          (dmem_wr_data_Q103H),
        .rdata       (dmem_rsp_rdata),
        .be          (dmem_req_be),
        .wdata       (dmem_req_wdata),
        .ld_data     (ld_data)
    );

    assign dmem_req_addr = {alu_out_Q103H[31:2], 2'b00};
    assign dmem_req_we   = ctrl.mem_wr_en & ~ctrl.mem_rd_en;
    assign wb_data_Q103H = (ctrl.sel_wb == SEL_WB_PC4) ? pc_plus4_Q103H : alu_out_Q103H;

    // Classify the Q103H op; a flush only counts while no load is outstanding.
    always_comb begin
        any_mem   = ctrl.mem_rd_en | ctrl.mem_wr_en;
        misalign  = any_mem & addr_misaligned(ctrl.mem_size, alu_out_Q103H[1:0]);
        flush_eff = flush_Q103H & (state_q == ST_IDLE);
        mem_req   = any_mem & ~flush_eff & ~misalign;
    end

    // Handshake FSM: request in IDLE, hold the pipe until the load response.
    always_comb begin
        state_d        = state_q;
        dmem_req_valid = 1'b0;
        stall_Q103H    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    dmem_req_valid = 1'b1;
                    if (!dmem_req_ready) begin
                        stall_Q103H = 1'b1;
                    end else if (ctrl.mem_rd_en) begin
                        stall_Q103H = 1'b1;
                        state_d     = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_Q103H = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next Q104H contents: real result when the stage advances, bubble while stalled.
    always_comb begin
        wb_data_d  = wb_data_q;
        rd_d       = rd_q;
        reg_we_d   = 1'b0;
        misalign_d = 1'b0;
        if (!stall_Q103H) begin
            wb_data_d  = (ctrl.sel_wb == SEL_WB_MEM) ? ld_data : wb_data_Q103H;
            rd_d       = ctrl.rd_Q103H;
            reg_we_d   = ctrl.reg_write_en_Q103H & ~flush_eff & ~misalign;
            misalign_d = misalign & ~flush_eff;
        end
    end

    // State and Q104H registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wb_data_q  <= 32'd0;
            rd_q       <= 5'd0;
            reg_we_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_data_q  <= wb_data_d;
            rd_q       <= rd_d;
            reg_we_q   <= reg_we_d;
            misalign_q <= misalign_d;
        end
    end

    assign wb_data_Q104H      = wb_data_q;
    assign rd_Q104H           = rd_q;
    assign reg_write_en_Q104H = reg_we_q;
    assign misalign_Q104H     = misalign_q;

endmodule

// File: tb/tb_rv_mem.sv
// Randomized bench for rv_mem against a transaction-level reference.
import rv_mem_pkg::*;

module tb_rv_mem;

    logic        clk;
    logic        rst;
    t_mem_ctrl   ctrl;
    logic        flush_Q103H;
    logic [31:0] alu_out_Q103H;
    logic [31:0] pc_plus4_Q103H;
    logic [31:0] dmem_wr_data_Q103H;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [3:0]  dmem_req_be;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        stall_Q103H;
    logic [31:0] wb_data_Q103H;
    logic [31:0] wb_data_Q104H;
    logic [4:0]  rd_Q104H;
    logic        reg_write_en_Q104H;
    logic        misalign_Q104H;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_wb_q;
    logic [4:0]  exp_rd_q;

    rv_mem dut (
        .clk                (clk),
        .rst                (rst),
        .ctrl               (ctrl),
        .flush_Q103H        (flush_Q103H),
        .alu_out_Q103H      (alu_out_Q103H),
        .pc_plus4_Q103H     (pc_plus4_Q103H),
        .dmem_wr_data_Q103H (dmem_wr_data_Q103H),
        .dmem_req_valid     (dmem_req_valid),
        .dmem_req_ready     (dmem_req_ready),
        .dmem_req_we        (dmem_req_we),
        .dmem_req_addr      (dmem_req_addr),
        .dmem_req_be        (dmem_req_be),
        .dmem_req_wdata     (dmem_req_wdata),
        .dmem_rsp_valid     (dmem_rsp_valid),
        .dmem_rsp_rdata     (dmem_rsp_rdata),
        .stall_Q103H        (stall_Q103H),
        .wb_data_Q103H      (wb_data_Q103H),
        .wb_data_Q104H      (wb_data_Q104H),
        .rd_Q104H           (rd_Q104H),
        .reg_write_en_Q104H (reg_write_en_Q104H),
        .misalign_Q104H     (misalign_Q104H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic ref_misaligned(input t_mem_size sz, input logic [31:0] a);
        if (sz == MEM_H) return a[0];
        if (sz == MEM_W) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input t_mem_size sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (sz == MEM_B) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == MEM_H) begin
            v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic set_nop();
        ctrl               = '0;
        flush_Q103H        = 1'b0;
        alu_out_Q103H      = 32'd0;
        pc_plus4_Q103H     = 32'd0;
        dmem_wr_data_Q103H = 32'd0;
        dmem_req_ready     = 1'b0;
        dmem_rsp_valid     = 1'b0;
        dmem_rsp_rdata     = 32'd0;
    endtask

    // One Q103H instruction from presentation to its Q104H result.
    task automatic do_op(input logic rd_en, input logic wr_en, input t_mem_size sz, input logic uns,
                         input t_sel_wb sel, input logic [4:0] rd, input logic rwe, input logic fl,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] wd,
                         input int rdy_dly, input int rsp_dly, input logic [31:0] rdat,
                         input logic fl_wait);
        logic        mis, issue, is_ld;
        int          n_req, stalls, exp_stalls;
        logic [31:0] exp_be, exp_wdata, res_wb;
        mis   = (rd_en | wr_en) & ref_misaligned(sz, alu);
        issue = (rd_en | wr_en) & ~fl & ~mis;
        is_ld = issue & rd_en;
        if (sz == MEM_B) begin
            exp_be    = 32'd1 << (alu % 4);
            exp_wdata = (wd & 32'hFF) * 32'h01010101;
        end else if (sz == MEM_H) begin
            exp_be    = ((alu % 4) >= 2) ? 32'hC : 32'h3;
            exp_wdata = (wd & 32'hFFFF) * 32'h00010001;
        end else begin
            exp_be    = 32'hF;
            exp_wdata = wd;
        end
        ctrl.mem_rd_en          = rd_en;
        ctrl.mem_wr_en          = wr_en;
        ctrl.mem_size           = sz;
        ctrl.mem_unsigned       = uns;
        ctrl.sel_wb             = sel;
        ctrl.rd_Q103H           = rd;
        ctrl.reg_write_en_Q103H = rwe;
        flush_Q103H             = fl;
        alu_out_Q103H           = alu;
        pc_plus4_Q103H          = pc4;
        dmem_wr_data_Q103H      = wd;
        stalls     = 0;
        exp_stalls = issue ? (rdy_dly + (rd_en ? 1 + rsp_dly : 0)) : 0;
        res_wb     = 32'd0;
        n_req      = issue ? rdy_dly : 0;
        for (int k = 0; k <= n_req; k++) begin
            dmem_req_ready = (k == n_req);
            dmem_rsp_valid = 1'($urandom_range(0, 1));
            dmem_rsp_rdata = $urandom;
            #1;
            chk("req_valid", dmem_req_valid, issue);
            if (issue) begin
                chk("req_addr", dmem_req_addr, alu & 32'hFFFFFFFC);
                chk("req_we", dmem_req_we, wr_en);
                chk("req_be", dmem_req_be, exp_be);
                chk("req_wdata", dmem_req_wdata, exp_wdata);
            end
            chk("stall_req", stall_Q103H, issue && (k < n_req || rd_en));
            chk("wb103", wb_data_Q103H, (sel == SEL_WB_PC4) ? pc4 : alu);
            if (stall_Q103H) stalls++;
            if (k == n_req && !is_ld)
                res_wb = (sel == SEL_WB_MEM) ? ref_load(sz, uns, alu, dmem_rsp_rdata)
                       : (sel == SEL_WB_PC4) ? pc4 : alu;
            step();
            if (k < n_req || is_ld) begin
                chk("bubble_we", reg_write_en_Q104H, 0);
                chk("bubble_mis", misalign_Q104H, 0);
                chk("bubble_rd", rd_Q104H, exp_rd_q);
                chk("bubble_wb", wb_data_Q104H, exp_wb_q);
            end
        end
        if (is_ld) begin
            for (int k = 0; k <= rsp_dly; k++) begin
                dmem_req_ready = 1'($urandom_range(0, 1));
                flush_Q103H    = fl_wait;
                dmem_rsp_valid = (k == rsp_dly);
                dmem_rsp_rdata = (k == rsp_dly) ? rdat : $urandom;
                #1;
                chk("wait_valid", dmem_req_valid, 0);
                chk("stall_wait", stall_Q103H, k < rsp_dly);
                if (stall_Q103H) stalls++;
                if (k == rsp_dly)
                    res_wb = (sel == SEL_WB_MEM) ? ref_load(sz, uns, alu, rdat)
                           : (sel == SEL_WB_PC4) ? pc4 : alu;
                step();
                if (k < rsp_dly) begin
                    chk("bubble_we", reg_write_en_Q104H, 0);
                    chk("bubble_rd", rd_Q104H, exp_rd_q);
                end
            end
        end
        chk("stall_cycles", stalls, exp_stalls);
        chk("wb104", wb_data_Q104H, res_wb);
        chk("rd104", rd_Q104H, rd);
        chk("we104", reg_write_en_Q104H, rwe & ~fl & ~mis);
        chk("mis104", misalign_Q104H, mis & ~fl);
        exp_wb_q = res_wb;
        exp_rd_q = rd;
        dmem_rsp_valid = 1'b0;
        flush_Q103H    = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        set_nop();
        exp_wb_q = 32'd0;
        exp_rd_q = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", dmem_req_valid, 0);
        chk("rst_stall", stall_Q103H, 0);
        chk("rst_wb", wb_data_Q104H, 0);
        chk("rst_rd", rd_Q104H, 0);
        chk("rst_we", reg_write_en_Q104H, 0);
        chk("rst_mis", misalign_Q104H, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // SW 0x100
        do_op(0, 1, MEM_W, 0, SEL_WB_ALU, 5'd3, 0, 0, 32'h100, 32'h4, 32'hDEADBEEF, 0, 0, 0, 0);
        chk("sw_we", reg_write_en_Q104H, 0);
        // SB 0x103
        do_op(0, 1, MEM_B, 0, SEL_WB_ALU, 5'd4, 0, 0, 32'h103, 32'h8, 32'h000000A5, 0, 0, 0, 0);
        // LB / LBU 0x102, two wait cycles
        do_op(1, 0, MEM_B, 0, SEL_WB_MEM, 5'd5, 1, 0, 32'h102, 32'hC, 32'd0, 0, 2, 32'h1280FF00, 1);
        chk("lb_val", wb_data_Q104H, 32'hFFFFFF80);
        do_op(1, 0, MEM_B, 1, SEL_WB_MEM, 5'd6, 1, 0, 32'h102, 32'h10, 32'd0, 0, 2, 32'h1280FF00, 0);
        chk("lbu_val", wb_data_Q104H, 32'h00000080);
        // LH misaligned
        do_op(1, 0, MEM_H, 0, SEL_WB_MEM, 5'd7, 1, 0, 32'h101, 32'h14, 32'd0, 0, 0, 0, 0);
        chk("lh_mis", misalign_Q104H, 1);
        chk("lh_we", reg_write_en_Q104H, 0);
        // LW with three not-ready cycles
        do_op(1, 0, MEM_W, 0, SEL_WB_MEM, 5'd9, 1, 0, 32'h200, 32'h18, 32'd0, 3, 1, 32'h12345678, 0);
        chk("lw_val", wb_data_Q104H, 32'h12345678);
        chk("lw_rd", rd_Q104H, 9);
        // flushed load issues nothing
        do_op(1, 0, MEM_W, 0, SEL_WB_MEM, 5'd10, 1, 1, 32'h300, 32'h1C, 32'd0, 2, 2, 32'h0, 0);

        // Reset while a load is outstanding, then a stale response.
        ctrl.mem_rd_en = 1'b1; ctrl.mem_wr_en = 1'b0; ctrl.mem_size = MEM_W;
        ctrl.sel_wb = SEL_WB_MEM; ctrl.rd_Q103H = 5'd11; ctrl.reg_write_en_Q103H = 1'b1;
        alu_out_Q103H = 32'h400; dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
        step();
        #1;
        chk("rwait_stall", stall_Q103H, 1);
        set_nop();
        rst = 1'b0;
        #1;
        chk("rwait_we", reg_write_en_Q104H, 0);
        chk("rwait_wb", wb_data_Q104H, 0);
        chk("rwait_rd", rd_Q104H, 0);
        chk("rwait_mis", misalign_Q104H, 0);
        chk("rwait_st", stall_Q103H, 0);
        @(negedge clk);
        rst = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hCAFEF00D;
        #1;
        chk("stale_stall", stall_Q103H, 0);
        step();
        chk("stale_we", reg_write_en_Q104H, 0);
        dmem_rsp_valid = 1'b0;
        exp_wb_q = wb_data_Q104H === 32'd0 ? 32'd0 : 32'hxxxxxxxx;
        exp_wb_q = 32'd0;
        exp_rd_q = 5'd0;
        // A store must now be accepted straight from IDLE.
        do_op(0, 1, MEM_H, 0, SEL_WB_ALU, 5'd12, 0, 0, 32'h502, 32'h20, 32'h0000BEEF, 0, 0, 0, 0);

        // Random instruction mix.
        for (int i = 0; i < 300; i++) begin
            logic rd_en, wr_en;
            int   kind;
            kind  = $urandom_range(0, 2);
            rd_en = (kind == 0);
            wr_en = (kind == 1);
            do_op(rd_en, wr_en, t_mem_size'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  t_sel_wb'($urandom_range(0, 2)), 5'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
